// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit buffer: launch FSM encoding,
// MMIO addresses and default sizing.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } tx_state_t;

  localparam logic [7:0] UART_DATA_ADDR = 8'd253;
  localparam logic [7:0] UART_STAT_ADDR = 8'd254;

  localparam int DEFAULT_DEPTH        = 8;
  localparam int DEFAULT_BUSY_TIMEOUT = 15;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Byte FIFO with registered occupancy flags. A push into a full FIFO is
// still accepted when a pop happens on the same edge.
module uart_tx_fifo_sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [7:0]        wr_data,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              accept
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_pop;
  logic [ADDR_W:0]   count_next;

  assign do_pop  = pop & ~empty;
  assign accept  = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({accept, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (ADDR_W+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage needs no reset: only entries behind the write pointer are read.
  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer between the CPU data-register write and the UART begin/busy
// handshake. Handshake: one uart_begin pulse per byte, then wait for busy to
// rise (bounded by BUSY_TIMEOUT) and fall before the next launch.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              tx_en,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              uart_busy,
  output logic              uart_begin,
  output logic [7:0]        uart_data,
  input  logic              clr_overflow,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

  tx_state_t         state;
  tx_state_t         state_next;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_cnt_next;
  logic              launch;
  logic              accept;
  logic [7:0]        head;

  uart_tx_fifo_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (wr_en),
    .pop     (launch),
    .wr_data (wr_data),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .accept  (accept)
  );

  always_comb begin
    state_next  = state;
    to_cnt_next = to_cnt;
    launch      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && tx_en && !uart_busy) begin
          state_next = S_LAUNCH;
          launch     = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_next  = S_WAIT_BUSY;
        to_cnt_next = '0;
      end
      S_WAIT_BUSY: begin
        if (uart_busy) begin
          state_next = S_WAIT_DONE;
        end else begin
          // A UART that never answers is abandoned; the byte counts as sent.
          to_cnt_next = to_cnt + 1'b1;
          if (to_cnt_next == TO_W'(BUSY_TIMEOUT)) state_next = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!uart_busy) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      to_cnt     <= '0;
      uart_begin <= 1'b0;
      uart_data  <= 8'h00;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      to_cnt     <= to_cnt_next;
      uart_begin <= (state_next == S_LAUNCH);
      if (launch) uart_data <= head;
      // A dropped write on the same edge as a clear leaves the flag set.
      overflow   <= (wr_en & ~accept) | (overflow & ~clr_overflow);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: bytes expected on the UART are queued at
// write time and checked in launch order by an independent monitor.
module tb_uart_tx_fifo;

  localparam int DEPTH        = 8;
  localparam int ADDR_W       = 3;
  localparam int BUSY_TIMEOUT = 15;

  logic              clock;
  logic              reset_n;
  logic              tx_en;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              uart_busy;
  logic              uart_begin;
  logic [7:0]        uart_data;
  logic              clr_overflow;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic [1:0]        dbg_state;

  uart_tx_fifo #(
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .tx_en        (tx_en),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .uart_busy    (uart_busy),
    .uart_begin   (uart_begin),
    .uart_data    (uart_data),
    .clr_overflow (clr_overflow),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int  n_checks   = 0;
  int  n_fail     = 0;
  int  n_begin    = 0;
  int  last_begin = 0;
  int  begin_gap  = 0;
  bit  prev_begin = 1'b0;
  bit  saw_full   = 1'b0;
  bit  model_ovf  = 1'b0;

  // UART transmitter model controls
  bit  uart_respond = 1'b1;
  int  busy_delay   = 2;
  int  busy_hold    = 100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cycle);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset_n) begin
      if (full) saw_full = 1'b1;
      if (uart_begin) begin
        if (prev_begin) fail_now("begin_width", "uart_begin high two cycles in a row");
        n_begin++;
        begin_gap  = cycle - last_begin;
        last_begin = cycle;
        if (exp_q.size() == 0) fail_now("unexpected_begin", "launch with no byte expected");
        else check("uart_data", uart_data, exp_q.pop_front());
      end
      prev_begin = uart_begin;
    end else begin
      prev_begin = 1'b0;
    end
  end

  // ---------------- UART transmitter model ----------------
  initial begin
    uart_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n && uart_begin && uart_respond) begin
        repeat (busy_delay) @(negedge clock);
        uart_busy = 1'b1;
        repeat (busy_hold) @(negedge clock);
        uart_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Occupancy before an edge is the number of bytes queued but not yet
  // launched; a write is kept if there is room or a launch shares the edge.
  task automatic write_byte(input logic [7:0] b, input bit pop_same_edge);
    @(negedge clock);
    wr_en   = 1'b1;
    wr_data = b;
    @(posedge clock);
    if (exp_q.size() < DEPTH || pop_same_edge) exp_q.push_back(b);
    else model_ovf = 1'b1;
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || uart_busy || dbg_state != 2'd0) && t < 4000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 4000) fail_now(name, "drain did not complete within 4000 cycles");
    repeat (3) @(negedge clock);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nb;
    reset_n      = 1'b0;
    tx_en        = 1'b1;
    wr_en        = 1'b0;
    wr_data      = 8'h00;
    clr_overflow = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_count", count, 0);
    check("rst_begin", uart_begin, 0);
    reset_n = 1'b1;

    // Reset values, and no launches from an empty FIFO
    @(negedge clock);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_uart_data", uart_data, 8'h00);
    repeat (20) @(negedge clock);
    check("rst_no_pulses", n_begin, 0);

    // Single byte: latency and data
    busy_delay = 2;
    busy_hold  = 100;
    nb = n_begin;
    write_byte(8'h41, 1'b0);
    @(negedge clock);
    check("single_begin_n0", uart_begin, 0);
    @(negedge clock);
    check("single_begin_n1", uart_begin, 1);
    check("single_data_n1", uart_data, 8'h41);
    @(negedge clock);
    check("single_begin_n2", uart_begin, 0);
    wait_drain("single_drain");
    repeat (20) @(negedge clock);
    check("single_count", count, 0);
    check("single_pulses", n_begin - nb, 1);
    check("single_data_held", uart_data, 8'h41);

    // Burst of eight on consecutive edges; FIFO never fills
    busy_hold = 50;
    saw_full  = 1'b0;
    nb = n_begin;
    for (int i = 0; i < 8; i++) write_byte(8'h10 + 8'(i), 1'b0);
    wait_drain("burst_drain");
    check("burst_pulses", n_begin - nb, 8);
    check("burst_never_full", saw_full, 0);

    // Overflow with transmitter disabled
    @(negedge clock);
    tx_en = 1'b0;
    for (int i = 0; i < 9; i++) write_byte(8'($urandom), 1'b0);
    @(negedge clock);
    check("ovf_count", count, exp_q.size());
    check("ovf_full", full, 1);
    check("ovf_flag", overflow, model_ovf);
    // Dropped write and clear on the same edge: flag stays set
    @(negedge clock);
    wr_en        = 1'b1;
    wr_data      = 8'hEE;
    clr_overflow = 1'b1;
    @(negedge clock);
    wr_en        = 1'b0;
    clr_overflow = 1'b0;
    check("ovf_set_wins", overflow, 1);
    @(negedge clock);
    clr_overflow = 1'b1;
    @(negedge clock);
    clr_overflow = 1'b0;
    model_ovf    = 1'b0;
    check("ovf_cleared", overflow, model_ovf);
    check("ovf_retained", count, exp_q.size());
    busy_hold = $urandom_range(3, 20);
    tx_en = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_drained", count, 0);

    // Full FIFO: write lands on the launch edge
    @(negedge clock);
    tx_en = 1'b0;
    for (int i = 0; i < 8; i++) write_byte(8'($urandom), 1'b0);
    @(negedge clock);
    check("pp_full_before", full, 1);
    tx_en   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    @(posedge clock);
    exp_q.push_back(8'hA5);
    #1;
    wr_en = 1'b0;
    @(negedge clock);
    check("pp_count", count, DEPTH);
    check("pp_overflow", overflow, 0);
    wait_drain("pp_drain");

    // Randomized bursts with random UART timing and tx_en gating
    for (int r = 0; r < 6; r++) begin
      int n;
      busy_delay = $urandom_range(1, 4);
      busy_hold  = $urandom_range(3, 20);
      n = $urandom_range(1, 6);
      @(negedge clock);
      tx_en = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clock);
        write_byte(8'($urandom), 1'b0);
      end
      @(negedge clock);
      tx_en = 1'b1;
      wait_drain("rand_drain");
      check("rand_empty", empty, 1);
    end

    // Timeout: UART never raises busy
    uart_respond = 1'b0;
    nb = n_begin;
    write_byte(8'h5A, 1'b0);
    write_byte(8'hC3, 1'b0);
    begin
      int t;
      t = 0;
      while (n_begin - nb < 2 && t < 100) begin
        @(negedge clock);
        t++;
      end
      if (t >= 100) fail_now("timeout_relaunch", "second byte never launched");
    end
    check("timeout_spacing", begin_gap, BUSY_TIMEOUT + 2);
    wait_drain("timeout_drain");

    // Reset while bytes are queued and a launch is in progress
    @(negedge clock);
    tx_en = 1'b0;
    for (int i = 0; i < 5; i++) write_byte(8'($urandom), 1'b0);
    nb = n_begin;
    @(negedge clock);
    tx_en = 1'b1;
    begin
      int t;
      t = 0;
      while (!uart_begin && t < 10) begin
        @(negedge clock);
        t++;
      end
      if (t >= 10) fail_now("reset_launch", "launch before reset never seen");
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_begin_drop", uart_begin, 0);
    check("reset_count", count, 0);
    check("reset_empty", empty, 1);
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    check("reset_no_launch", n_begin - nb, 1);
    check("reset_count_after", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    fail_now("watchdog", "simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
